// File: rtl/pong_game_fsm.sv
// Pong game-flow controller: start/serve/point/game-over sequencing that drives
// the score counter (d_inc/d_clr) and gates ball motion. All outputs registered.
module pong_game_fsm #(
  parameter int unsigned WAIT_TICKS = 120,
  parameter logic [7:0]  WIN_SCORE  = 8'h11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       refr_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  output logic [1:0] d_inc,
  output logic       d_clr,
  output logic       ball_en,
  output logic       serve_dir,
  output logic       game_over,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_POINT = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam logic [7:0] WAIT_T = 8'(WAIT_TICKS);

  logic [1:0] state_q, state_d;
  logic       btn_q;
  logic       armed_q;
  logic [7:0] tick_q, tick_d;
  logic [2:0] settle_q, settle_d;
  logic [1:0] d_inc_q, d_inc_d;
  logic       d_clr_q, d_clr_d;
  logic       serve_q, serve_d;
  logic       ball_en_q, ball_en_d;
  logic       game_over_q, game_over_d;

  logic start_ev;
  logic expired;
  logic win;

  // armed_q masks the first edge after reset so a button already held at
  // deassertion is captured into btn_q without counting as a press.
  assign start_ev = btn_start & ~btn_q & armed_q;
  assign expired  = (tick_q == WAIT_T) && (settle_q >= 3'd4);
  assign win      = ({dig1, dig0} == WIN_SCORE) || ({dig3, dig2} == WIN_SCORE);

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    settle_d = settle_q;
    d_inc_d  = 2'b00;
    d_clr_d  = 1'b0;
    serve_d  = serve_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_ev) begin
          state_d = S_PLAY;
          d_clr_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (miss_left || miss_right) begin
          state_d  = S_POINT;
          tick_d   = 8'd0;
          settle_d = 3'd0;
          if (miss_left && !miss_right) begin
            d_inc_d = 2'b10;
            serve_d = 1'b0;
          end else if (miss_right && !miss_left) begin
            d_inc_d = 2'b01;
            serve_d = 1'b1;
          end
        end
      end
      S_POINT: begin
        if (expired) begin
          state_d = win ? S_OVER : S_PLAY;
        end else begin
          // Tick count holds at WAIT_T so fast ticks cannot overshoot the
          // equality test while the settle guard is still running.
          if (refr_tick && (tick_q != WAIT_T)) tick_d = tick_q + 8'd1;
          if (settle_q != 3'd7) settle_d = settle_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ball_en_d   = (state_d == S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      btn_q       <= 1'b0;
      armed_q     <= 1'b0;
      tick_q      <= 8'd0;
      settle_q    <= 3'd0;
      d_inc_q     <= 2'b00;
      d_clr_q     <= 1'b0;
      serve_q     <= 1'b0;
      ball_en_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_start;
      armed_q     <= 1'b1;
      tick_q      <= tick_d;
      settle_q    <= settle_d;
      d_inc_q     <= d_inc_d;
      d_clr_q     <= d_clr_d;
      serve_q     <= serve_d;
      ball_en_q   <= ball_en_d;
      game_over_q <= game_over_d;
    end
  end

  assign d_inc     = d_inc_q;
  assign d_clr     = d_clr_q;
  assign ball_en   = ball_en_q;
  assign serve_dir = serve_q;
  assign game_over = game_over_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pong_game_fsm.sv
// Bench for pong_game_fsm: default-parameter instance for the game flow and a
// WAIT_TICKS=1 instance for the post-point settle guard.
module tb_pong_game_fsm;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_POINT = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_start, refr_tick, miss_left, miss_right;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic [1:0] d_inc, dbg_state;
  logic       d_clr, ball_en, serve_dir, game_over;

  logic       s_btn, s_refr, s_ml, s_mr;
  logic [1:0] s_d_inc, s_dbg_state;
  logic       s_d_clr, s_ball_en, s_serve_dir, s_game_over;

  logic [7:0] obs, s_obs;
  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  pong_game_fsm dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .refr_tick(refr_tick),
    .miss_left(miss_left), .miss_right(miss_right),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .d_inc(d_inc), .d_clr(d_clr), .ball_en(ball_en), .serve_dir(serve_dir),
    .game_over(game_over), .dbg_state(dbg_state)
  );

  pong_game_fsm #(.WAIT_TICKS(1)) dut_w1 (
    .clk(clk), .reset(reset), .btn_start(s_btn), .refr_tick(s_refr),
    .miss_left(s_ml), .miss_right(s_mr),
    .dig0(4'd0), .dig1(4'd0), .dig2(4'd0), .dig3(4'd0),
    .d_inc(s_d_inc), .d_clr(s_d_clr), .ball_en(s_ball_en), .serve_dir(s_serve_dir),
    .game_over(s_game_over), .dbg_state(s_dbg_state)
  );

  assign obs   = {dbg_state, d_inc, d_clr, ball_en, serve_dir, game_over};
  assign s_obs = {s_dbg_state, s_d_inc, s_d_clr, s_ball_en, s_serve_dir, s_game_over};

  function automatic logic [7:0] ex(input logic [1:0] st, input logic [1:0] inc,
                                    input logic clr, input logic srv);
    return {st, inc, clr, (st == ST_PLAY), srv, (st == ST_OVER)};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic pop_check(input string tag, input logic [7:0] got);
    logic [7:0] w;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got=%b want=<empty queue>", tag, got);
    end else begin
      w = exp_q.pop_front();
      check(tag, got, w);
    end
  endtask

  task automatic drive(input string tag, input logic bs, input logic rt,
                       input logic ml, input logic mr, input logic [7:0] e);
    btn_start = bs; refr_tick = rt; miss_left = ml; miss_right = mr;
    exp_q.push_back(e);
    @(posedge clk); #1;
    pop_check(tag, obs);
  endtask

  task automatic s_drive(input string tag, input logic bs, input logic rt,
                         input logic ml, input logic mr, input logic [7:0] e);
    s_btn = bs; s_refr = rt; s_ml = ml; s_mr = mr;
    exp_q.push_back(e);
    @(posedge clk); #1;
    pop_check(tag, s_obs);
  endtask

  // POINT pause: quiet cycle, a tick coinciding with a start edge and a miss
  // (both ignored), then 119 more ticks; exit exactly one cycle after tick 120.
  task automatic point_run(input string tag, input logic srv, input logic [1:0] exit_st);
    drive({tag, "_quiet"}, 0, 0, 0, 0, ex(ST_POINT, 2'b00, 0, srv));
    drive({tag, "_ign"},   1, 1, 1, 0, ex(ST_POINT, 2'b00, 0, srv));
    for (int i = 0; i < 119; i++)
      drive({tag, "_wait"}, 0, 1, 0, 0, ex(ST_POINT, 2'b00, 0, srv));
    drive({tag, "_exit"}, 0, 0, 0, 0, ex(exit_st, 2'b00, 0, srv));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    btn_start = 0; refr_tick = 0; miss_left = 0; miss_right = 0;
    s_btn = 0; s_refr = 0; s_ml = 0; s_mr = 0;
    dig0 = 0; dig1 = 0; dig2 = 0; dig3 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs, ex(ST_IDLE, 2'b00, 0, 0));
    check("reset_state_w1", s_obs, ex(ST_IDLE, 2'b00, 0, 0));

    // Button already held when reset releases: no start event.
    btn_start = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive("held_at_release", 1, 0, 0, 0, ex(ST_IDLE, 2'b00, 0, 0));
    drive("idle_miss", 0, 0, 1, 1, ex(ST_IDLE, 2'b00, 0, 0));

    drive("start", 1, 0, 0, 0, ex(ST_PLAY, 2'b00, 1, 0));
    for (int i = 0; i < 100; i++) drive("start_hold", 1, 0, 0, 0, ex(ST_PLAY, 2'b00, 0, 0));
    drive("btn_release", 0, 0, 0, 0, ex(ST_PLAY, 2'b00, 0, 0));
    drive("start_in_play", 1, 0, 0, 0, ex(ST_PLAY, 2'b00, 0, 0));
    drive("play_tick", 0, 1, 0, 0, ex(ST_PLAY, 2'b00, 0, 0));

    drive("miss_right", 0, 0, 0, 1, ex(ST_POINT, 2'b01, 0, 1));
    point_run("pt1", 1, ST_PLAY);

    drive("both_miss", 0, 0, 1, 1, ex(ST_POINT, 2'b00, 0, 1));
    point_run("pt2", 1, ST_PLAY);

    dig1 = 4'd1; dig0 = 4'd0;
    drive("miss_left", 0, 0, 1, 0, ex(ST_POINT, 2'b10, 0, 0));
    point_run("pt3_no_win", 0, ST_PLAY);

    drive("miss_left_win", 0, 0, 1, 0, ex(ST_POINT, 2'b10, 0, 0));
    dig3 = 4'd1; dig2 = 4'd1;
    point_run("pt4_win", 0, ST_OVER);
    drive("over_miss", 0, 1, 1, 0, ex(ST_OVER, 2'b00, 0, 0));
    drive("over_miss_r", 0, 0, 0, 1, ex(ST_OVER, 2'b00, 0, 0));
    drive("restart", 1, 0, 0, 0, ex(ST_PLAY, 2'b00, 1, 0));
    drive("restart_after", 0, 0, 0, 0, ex(ST_PLAY, 2'b00, 0, 0));
    dig0 = 0; dig1 = 0; dig2 = 0; dig3 = 0;

    // Asynchronous reset between edges while in POINT.
    drive("miss_right2", 0, 0, 0, 1, ex(ST_POINT, 2'b01, 0, 1));
    drive("pt5", 0, 1, 0, 0, ex(ST_POINT, 2'b00, 0, 1));
    #2 reset = 1'b1;
    #1 check("async_reset", obs, ex(ST_IDLE, 2'b00, 0, 0));
    @(posedge clk); #1;
    drive("in_reset", 0, 1, 1, 0, ex(ST_IDLE, 2'b00, 0, 0));
    reset = 1'b0;
    drive("post_reset", 0, 0, 0, 1, ex(ST_IDLE, 2'b00, 0, 0));
    drive("post_reset2", 0, 1, 0, 0, ex(ST_IDLE, 2'b00, 0, 0));

    // Settle guard with WAIT_TICKS=1: tick on first POINT cycle, exit after 5.
    s_drive("w1_start", 1, 0, 0, 0, ex(ST_PLAY, 2'b00, 1, 0));
    s_drive("w1_play", 0, 0, 0, 0, ex(ST_PLAY, 2'b00, 0, 0));
    s_drive("w1_miss", 0, 0, 0, 1, ex(ST_POINT, 2'b01, 0, 1));
    s_drive("w1_tick", 0, 1, 0, 0, ex(ST_POINT, 2'b00, 0, 1));
    for (int i = 0; i < 3; i++) s_drive("w1_settle", 0, 0, 0, 0, ex(ST_POINT, 2'b00, 0, 1));
    s_drive("w1_exit", 0, 0, 0, 0, ex(ST_PLAY, 2'b00, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
